// File: rtl/key_debounce_pkg.sv
// key_debounce_pkg: shared state encoding, 50 MHz default timing constants
// and counter sizing helpers for the key_debounce block.
package key_debounce_pkg;

  // Per-key debounce state machine encoding.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMING    = 2'd1,
    PRESSED   = 2'd2,
    DISARMING = 2'd3
  } key_state_e;

  // Default timing at 50 MHz.
  localparam int DEFAULT_DEBOUNCE_CYCLES     = 1_000_000;  // 20 ms
  localparam int DEFAULT_REPEAT_DELAY_CYCLES = 25_000_000; // 500 ms
  localparam int DEFAULT_REPEAT_RATE_CYCLES  = 5_000_000;  // 100 ms

  // Largest of three cycle counts.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) begin
      m = b;
    end else begin
      m = m;
    end
    if (c > m) begin
      m = c;
    end else begin
      m = m;
    end
    return m;
  endfunction

  // Counter width able to hold (largest cycle count - 1), never below 1 bit.
  function automatic int cnt_width(input int a, input int b, input int c);
    int w;
    w = $clog2(max3(a, b, c));
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/key_debounce_channel.sv
// debounce_channel: one pushbutton channel. Two-flop synchronizer on the raw
// active-low key, a four-state debounce FSM with a hold counter, and
// registered level / press / release outputs.
// Optional feature macro: KEY_DEBOUNCE_AUTOREPEAT_EN adds a repeat counter
// that re-fires the press strobe while the key stays held.
module debounce_channel
  import key_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES     = DEFAULT_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY_CYCLES = DEFAULT_REPEAT_DELAY_CYCLES,
  parameter int REPEAT_RATE_CYCLES  = DEFAULT_REPEAT_RATE_CYCLES
) (
  input  logic CLOCK_50,
  input  logic Resetn,
  input  logic key_raw,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY_CYCLES, REPEAT_RATE_CYCLES);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(1'b0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

  logic             sync_meta_r;
  logic             sync_r;
  logic             key_pressed_s;

  key_state_e       state_r;
  key_state_e       state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_s;
  logic             pressed_r;
  logic             pressed_s;
  logic             press_pulse_r;
  logic             press_pulse_s;
  logic             release_pulse_r;
  logic             release_pulse_s;

`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] REP_DELAY_LAST = CNT_W'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_RATE_LAST  = CNT_W'(REPEAT_RATE_CYCLES - 1);

  logic [CNT_W-1:0] rep_cnt_r;
  logic [CNT_W-1:0] rep_cnt_s;
  logic             rep_phase_r;  // 0: waiting for first repeat, 1: steady rate
  logic             rep_phase_s;
`endif

  // Bring the asynchronous key into the clock domain; reset reads as released.
  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      sync_meta_r <= 1'b1;
      sync_r      <= 1'b1;
    end else begin
      sync_meta_r <= key_raw;
      sync_r      <= sync_meta_r;
    end
  end

  // Internal polarity: 1 = key held down.
  assign key_pressed_s = ~sync_r;

  // State, counters and registered outputs.
  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      state_r         <= IDLE;
      cnt_r           <= CNT_ZERO;
      pressed_r       <= 1'b0;
      press_pulse_r   <= 1'b0;
      release_pulse_r <= 1'b0;
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
      rep_cnt_r       <= CNT_ZERO;
      rep_phase_r     <= 1'b0;
`endif
    end else begin
      state_r         <= state_s;
      cnt_r           <= cnt_s;
      pressed_r       <= pressed_s;
      press_pulse_r   <= press_pulse_s;
      release_pulse_r <= release_pulse_s;
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
      rep_cnt_r       <= rep_cnt_s;
      rep_phase_r     <= rep_phase_s;
`endif
    end
  end

  // Next-state, hold-counter and strobe decode for the debounce FSM.
  always_comb begin
    state_s         = state_r;
    cnt_s           = cnt_r;
    pressed_s       = pressed_r;
    press_pulse_s   = 1'b0;
    release_pulse_s = 1'b0;
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
    rep_cnt_s       = rep_cnt_r;
    rep_phase_s     = rep_phase_r;
`endif

    case (state_r)
      IDLE: begin
        cnt_s = CNT_ZERO;
        if (key_pressed_s) begin
          state_s = ARMING;
        end else begin
          state_s = IDLE;
        end
      end

      ARMING: begin
        if (!key_pressed_s) begin
          state_s = IDLE;
          cnt_s   = CNT_ZERO;
        end else if (cnt_r == DEB_LAST) begin
          state_s       = PRESSED;
          cnt_s         = CNT_ZERO;
          pressed_s     = 1'b1;
          press_pulse_s = 1'b1;
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
          rep_cnt_s     = CNT_ZERO;
          rep_phase_s   = 1'b0;
`endif
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end

      PRESSED: begin
        cnt_s = CNT_ZERO;
        if (!key_pressed_s) begin
          state_s = DISARMING;
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
          rep_cnt_s   = CNT_ZERO;
          rep_phase_s = 1'b0;
`endif
        end else begin
          state_s = PRESSED;
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
          // First repeat after the long delay, then at the steady rate.
          if (!rep_phase_r) begin
            if (rep_cnt_r == REP_DELAY_LAST) begin
              press_pulse_s = 1'b1;
              rep_cnt_s     = CNT_ZERO;
              rep_phase_s   = 1'b1;
            end else begin
              rep_cnt_s = rep_cnt_r + CNT_ONE;
            end
          end else begin
            if (rep_cnt_r == REP_RATE_LAST) begin
              press_pulse_s = 1'b1;
              rep_cnt_s     = CNT_ZERO;
            end else begin
              rep_cnt_s = rep_cnt_r + CNT_ONE;
            end
          end
`endif
        end
      end

      DISARMING: begin
        if (key_pressed_s) begin
          // Bounce back to held: no strobe, repeat timing restarts.
          state_s = PRESSED;
          cnt_s   = CNT_ZERO;
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
          rep_cnt_s   = CNT_ZERO;
          rep_phase_s = 1'b0;
`endif
        end else if (cnt_r == DEB_LAST) begin
          state_s         = IDLE;
          cnt_s           = CNT_ZERO;
          pressed_s       = 1'b0;
          release_pulse_s = 1'b1;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end

      default: begin
        state_s   = IDLE;
        cnt_s     = CNT_ZERO;
        pressed_s = 1'b0;
      end
    endcase
  end

  assign pressed       = pressed_r;
  assign press_pulse   = press_pulse_r;
  assign release_pulse = release_pulse_r;

endmodule

// File: rtl/key_debounce.sv
// key_debounce: debounced DE2 pushbuttons. One independent debounce_channel
// per KEY line producing a clean level plus one-cycle press/release strobes.
// Optional feature macro: KEY_DEBOUNCE_AUTOREPEAT_EN (auto-repeat PressPulse).
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int NUM_KEYS            = 4,
  parameter int DEBOUNCE_CYCLES     = DEFAULT_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY_CYCLES = DEFAULT_REPEAT_DELAY_CYCLES,
  parameter int REPEAT_RATE_CYCLES  = DEFAULT_REPEAT_RATE_CYCLES
) (
  input  logic                CLOCK_50,
  input  logic                Resetn,
  input  logic [NUM_KEYS-1:0] KEY,
  output logic [NUM_KEYS-1:0] Pressed,
  output logic [NUM_KEYS-1:0] PressPulse,
  output logic [NUM_KEYS-1:0] ReleasePulse
);

  // One fully independent debounce channel per key.
  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES     (DEBOUNCE_CYCLES),
      .REPEAT_DELAY_CYCLES (REPEAT_DELAY_CYCLES),
      .REPEAT_RATE_CYCLES  (REPEAT_RATE_CYCLES)
    ) u_chan (
      .CLOCK_50      (CLOCK_50),
      .Resetn        (Resetn),
      .key_raw       (KEY[i]),
      .pressed       (Pressed[i]),
      .press_pulse   (PressPulse[i]),
      .release_pulse (ReleasePulse[i])
    );
  end

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: table of per-cycle vectors {Resetn, KEY, expected outputs}
// built up front, applied in order through an expectation queue and compared
// one cycle later. Build with or without KEY_DEBOUNCE_AUTOREPEAT_EN.
module tb_key_debounce;

`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  typedef struct {
    logic       rstn;
    logic [3:0] key;
    logic [3:0] exp_pressed;
    logic [3:0] exp_pp;
    logic [3:0] exp_rp;
    bit         count_pp0;
  } vec_t;

  logic       CLOCK_50;
  logic       Resetn;
  logic [3:0] KEY;
  logic [3:0] Pressed;
  logic [3:0] PressPulse;
  logic [3:0] ReleasePulse;

  vec_t vec_q[$];
  vec_t exp_q[$];
  int   n_vec;
  int   n_miss;
  int   rep_pulses;

  key_debounce #(
    .NUM_KEYS            (4),
    .DEBOUNCE_CYCLES     (8),
    .REPEAT_DELAY_CYCLES (20),
    .REPEAT_RATE_CYCLES  (5)
  ) dut (
    .CLOCK_50     (CLOCK_50),
    .Resetn       (Resetn),
    .KEY          (KEY),
    .Pressed      (Pressed),
    .PressPulse   (PressPulse),
    .ReleasePulse (ReleasePulse)
  );

  initial begin
    CLOCK_50 = 1'b0;
    forever #5 CLOCK_50 = ~CLOCK_50;
  end

  function automatic void add(input logic r, input logic [3:0] k, input logic [3:0] p,
                              input logic [3:0] pp, input logic [3:0] rp, input bit c);
    vec_t v;
    v.rstn = r; v.key = k; v.exp_pressed = p; v.exp_pp = pp; v.exp_rp = rp; v.count_pp0 = c;
    vec_q.push_back(v);
  endfunction

  initial begin
    vec_t v;
    vec_t e;
    n_vec = 0;
    n_miss = 0;
    rep_pulses = 0;
    Resetn = 1'b0;
    KEY = 4'b1111;

    // Reset, then idle keys: nothing happens.
    for (int k = 0; k < 3; k++)  add(1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    for (int k = 0; k < 50; k++) add(1'b1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b0);

    // KEY[0] press and release: strobes on edge 10 of each.
    for (int k = 0; k < 25; k++)
      add(1'b1, 4'b1110, (k >= 10) ? 4'b0001 : 4'b0000, (k == 10) ? 4'b0001 : 4'b0000, 4'b0000, 1'b0);
    for (int k = 0; k < 20; k++)
      add(1'b1, 4'b1111, (k < 10) ? 4'b0001 : 4'b0000, 4'b0000, (k == 10) ? 4'b0001 : 4'b0000, 1'b0);

    // KEY[1] bouncing in 5-cycle bursts: never accepted.
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 5; k++) add(1'b1, 4'b1101, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      for (int k = 0; k < 5; k++) add(1'b1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    end
    for (int k = 0; k < 20; k++) add(1'b1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b0);

    // KEY[3:2] together.
    for (int k = 0; k < 20; k++)
      add(1'b1, 4'b0011, (k >= 10) ? 4'b1100 : 4'b0000, (k == 10) ? 4'b1100 : 4'b0000, 4'b0000, 1'b0);
    for (int k = 0; k < 20; k++)
      add(1'b1, 4'b1111, (k < 10) ? 4'b1100 : 4'b0000, 4'b0000, (k == 10) ? 4'b1100 : 4'b0000, 1'b0);

    // Reset mid-debounce with KEY[0] held: press re-debounced after reset.
    for (int k = 0; k < 6; k++) add(1'b1, 4'b1110, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    for (int k = 0; k < 3; k++) add(1'b0, 4'b1110, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    for (int k = 0; k < 25; k++)
      add(1'b1, 4'b1110, (k >= 10) ? 4'b0001 : 4'b0000, (k == 10) ? 4'b0001 : 4'b0000, 4'b0000, 1'b0);
    for (int k = 0; k < 20; k++)
      add(1'b1, 4'b1111, (k < 10) ? 4'b0001 : 4'b0000, 4'b0000, (k == 10) ? 4'b0001 : 4'b0000, 1'b0);

    // Long hold of KEY[0]: auto-repeat at accept+20, then every 5 (if built).
    for (int t = 0; t < 80; t++) begin
      bit pp;
      pp = (t == 10) || (REP && t >= 30 && t <= 60 && ((t - 30) % 5) == 0);
      add(1'b1, (t < 60) ? 4'b1110 : 4'b1111,
          (t >= 10 && t < 70) ? 4'b0001 : 4'b0000,
          pp ? 4'b0001 : 4'b0000,
          (t == 70) ? 4'b0001 : 4'b0000, 1'b1);
    end
    for (int k = 0; k < 10; k++) add(1'b1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b0);

    // Apply: drive, queue the expectation, sample 1 time unit after the edge.
    for (int i = 0; i < vec_q.size(); i++) begin
      v = vec_q[i];
      Resetn = v.rstn;
      KEY = v.key;
      exp_q.push_back(v);
      @(posedge CLOCK_50);
      #1;
      e = exp_q.pop_front();
      n_vec++;
      if (e.count_pp0 && PressPulse[0]) rep_pulses++;
      if (Pressed !== e.exp_pressed || PressPulse !== e.exp_pp || ReleasePulse !== e.exp_rp) begin
        n_miss++;
        $display("FAIL vec%0d: Pressed=%b PressPulse=%b ReleasePulse=%b, required %b %b %b",
                 i, Pressed, PressPulse, ReleasePulse, e.exp_pressed, e.exp_pp, e.exp_rp);
      end
    end

    // Total press strobes during the long hold.
    n_vec++;
    if (rep_pulses != (REP ? 8 : 1)) begin
      n_miss++;
      $display("FAIL repeat_count: got %0d press pulses, required %0d", rep_pulses, REP ? 8 : 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
